// File: rtl/snn_lif_stepper.sv
// Time-multiplexed leaky integrate-and-fire engine: N neurons, TS steps per job.
// Latency: one neuron update per accepted beat; step period N+1 cycles best case.
// Backpressure: in_ready only in RUN; out_spikes/out_step held while out_valid && !out_ready.
//
// Ports: aclk/aresetn (async active-low); start + cfg_* (sampled at start);
//   in_valid/in_ready/in_data/in_idx: one current beat per neuron per step;
//   out_valid/out_ready/out_spikes/out_step: per-step spike vector;
//   busy/done: job status; cnt_addr/cnt_data: registered spike-count readback.
// Optional feature: define SNN_SPIKE_COUNT_EN to build per-neuron saturating
//   spike counters; otherwise cnt_data is tied to 0.
module snn_lif_stepper #(
  parameter int N   = 32,
  parameter int TS  = 33,
  parameter int VW  = 16,
  parameter int IW  = 8,
  parameter int RPW = 4,
  parameter int NA  = $clog2(N),
  parameter int TW  = $clog2(TS + 1)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic signed [VW-1:0] cfg_v_0,
  input  logic signed [VW-1:0] cfg_v_rest,
  input  logic signed [VW-1:0] cfg_v_th,
  input  logic [4:0]           cfg_v_leak,
  input  logic [3:0]           cfg_k_syn,
  input  logic [RPW-1:0]       cfg_rp,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [IW-1:0] in_data,
  output logic [NA-1:0]        in_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_spikes,
  output logic [TW-1:0]        out_step,
  output logic                 busy,
  output logic                 done,
  input  logic [NA-1:0]        cnt_addr,
  output logic [TW-1:0]        cnt_data
);

  // Wide enough that v - leak + (in << 15) can never overflow before saturation.
  localparam int AW = VW + IW + 16;
  localparam logic signed [AW-1:0] V_MAX = {{(AW-VW+1){1'b0}}, {(VW-1){1'b1}}};
  localparam logic signed [AW-1:0] V_MIN = {{(AW-VW+1){1'b1}}, {(VW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_EMIT} state_t;
  state_t state;

  logic signed [VW-1:0] v      [N];
  logic [RPW-1:0]       rp_cnt [N];
  logic [N-1:0]         stage;
  logic [TW-1:0]        step;

  // Job configuration captured at start so mid-job port changes are harmless.
  logic signed [VW-1:0] v_0_q, v_rest_q, v_th_q;
  logic [4:0]           leak_q;
  logic [3:0]           k_q;
  logic [RPW-1:0]       rp_q;

  logic signed [AW-1:0] v_cur, v_rest_w, v_th_w, diff_w, leak_w, syn_w, u_w;
  logic signed [VW-1:0] v_sat;
  logic                 in_ref, spike_now;
  logic [N-1:0]         stage_nxt;

  // Datapath for the neuron currently addressed by in_idx.
  always_comb begin
    v_cur    = {{(AW-VW){v[in_idx][VW-1]}}, v[in_idx]};
    v_rest_w = {{(AW-VW){v_rest_q[VW-1]}}, v_rest_q};
    v_th_w   = {{(AW-VW){v_th_q[VW-1]}}, v_th_q};
    diff_w   = v_cur - v_rest_w;
    leak_w   = diff_w >>> leak_q;
    syn_w    = {{(AW-IW){in_data[IW-1]}}, in_data} << k_q;
    u_w      = v_cur - leak_w + syn_w;
    in_ref   = (rp_cnt[in_idx] != '0);
    spike_now = !in_ref && (u_w >= v_th_w);
    if (u_w > V_MAX)      v_sat = V_MAX[VW-1:0];
    else if (u_w < V_MIN) v_sat = V_MIN[VW-1:0];
    else                  v_sat = u_w[VW-1:0];
    // Include the beat being accepted so the last neuron lands in out_spikes.
    stage_nxt         = stage;
    stage_nxt[in_idx] = spike_now;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_idx     <= '0;
      out_spikes <= '0;
      out_step   <= '0;
      stage      <= '0;
      step       <= '0;
      v_0_q      <= '0;
      v_rest_q   <= '0;
      v_th_q     <= '0;
      leak_q     <= '0;
      k_q        <= '0;
      rp_q       <= '0;
      for (int n = 0; n < N; n++) begin
        v[n]      <= '0;
        rp_cnt[n] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            v_0_q    <= cfg_v_0;
            v_rest_q <= cfg_v_rest;
            v_th_q   <= cfg_v_th;
            leak_q   <= cfg_v_leak;
            k_q      <= cfg_k_syn;
            rp_q     <= cfg_rp;
            busy     <= 1'b1;
            state    <= S_INIT;
          end
        end
        S_INIT: begin
          for (int n = 0; n < N; n++) begin
            v[n]      <= v_0_q;
            rp_cnt[n] <= '0;
          end
          step     <= '0;
          in_idx   <= '0;
          stage    <= '0;
          in_ready <= 1'b1;
          state    <= S_RUN;
        end
        S_RUN: begin
          if (in_valid) begin
            if (in_ref) begin
              v[in_idx]      <= v_rest_q;
              rp_cnt[in_idx] <= rp_cnt[in_idx] - 1'b1;
            end else if (spike_now) begin
              v[in_idx]      <= v_rest_q;
              rp_cnt[in_idx] <= rp_q;
            end else begin
              v[in_idx] <= v_sat;
            end
            stage <= stage_nxt;
            if (in_idx == NA'(N - 1)) begin
              in_ready   <= 1'b0;
              out_valid  <= 1'b1;
              out_spikes <= stage_nxt;
              out_step   <= step;
              state      <= S_EMIT;
            end else begin
              in_idx <= in_idx + 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (step == TW'(TS - 1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              step     <= step + 1'b1;
              in_idx   <= '0;
              in_ready <= 1'b1;
              state    <= S_RUN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SNN_SPIKE_COUNT_EN
  logic [TW-1:0] cnt [N];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_data <= '0;
      for (int n = 0; n < N; n++) cnt[n] <= '0;
    end else begin
      if (state == S_INIT) begin
        for (int n = 0; n < N; n++) cnt[n] <= '0;
      end else if (state == S_RUN && in_valid && spike_now && cnt[in_idx] != '1) begin
        cnt[in_idx] <= cnt[in_idx] + 1'b1;
      end
      cnt_data <= (int'(cnt_addr) < N) ? cnt[cnt_addr] : '0;
    end
  end
`else
  logic unused_cnt_addr;
  assign unused_cnt_addr = ^cnt_addr;
  assign cnt_data        = '0;
`endif

endmodule

// File: tb/tb_snn_lif_stepper.sv
// Bench for snn_lif_stepper: N=4, TS=4 directed jobs with hand-computed spike
// vectors pushed to a queue and checked by an independent output monitor.
module tb_snn_lif_stepper;
  localparam int N   = 4;
  localparam int TS  = 4;
  localparam int VW  = 16;
  localparam int IW  = 8;
  localparam int RPW = 4;
  localparam int NA  = 2;
  localparam int TW  = 3;
`ifdef SNN_SPIKE_COUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic                 aclk = 1'b0;
  logic                 aresetn, start;
  logic signed [VW-1:0] cfg_v_0, cfg_v_rest, cfg_v_th;
  logic [4:0]           cfg_v_leak;
  logic [3:0]           cfg_k_syn;
  logic [RPW-1:0]       cfg_rp;
  logic                 in_valid, in_ready;
  logic signed [IW-1:0] in_data;
  logic [NA-1:0]        in_idx;
  logic                 out_valid, out_ready;
  logic [N-1:0]         out_spikes;
  logic [TW-1:0]        out_step;
  logic                 busy, done;
  logic [NA-1:0]        cnt_addr;
  logic [TW-1:0]        cnt_data;

  always #5 aclk = ~aclk;

  snn_lif_stepper #(.N(N), .TS(TS), .VW(VW), .IW(IW), .RPW(RPW)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .cfg_v_0(cfg_v_0), .cfg_v_rest(cfg_v_rest), .cfg_v_th(cfg_v_th),
    .cfg_v_leak(cfg_v_leak), .cfg_k_syn(cfg_k_syn), .cfg_rp(cfg_rp),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_idx(in_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_spikes(out_spikes),
    .out_step(out_step), .busy(busy), .done(done),
    .cnt_addr(cnt_addr), .cnt_data(cnt_data)
  );

  typedef struct {
    logic [N-1:0] spk;
    int           stp;
    bit           chk_v;
    int           v0;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_idx = 0;

  task automatic check(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(logic [N-1:0] s, int st, bit cv, int v);
    exp_t e;
    e.spk = s; e.stp = st; e.chk_v = cv; e.v0 = v;
    q.push_back(e);
  endfunction

  // Monitor: input index sequence and every output handshake against the queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        exp_idx = 0;
      end else begin
        if (in_valid && in_ready) begin
          check("in_idx", in_idx, exp_idx);
          exp_idx = (exp_idx == N - 1) ? 0 : exp_idx + 1;
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: got step %0d, expected no output", out_step);
          end else begin
            e = q.pop_front();
            check("out_spikes", out_spikes, e.spk);
            check("out_step", out_step, e.stp);
            if (e.chk_v) check("v_neuron0", dut.v[0], e.v0);
          end
        end
      end
    end
  end

  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_idx", in_idx, 0);
    check("rst_out_spikes", out_spikes, 0);
    check("rst_out_step", out_step, 0);
    check("rst_cnt_data", cnt_data, 0);
    check("rst_v0", dut.v[0], 0);
  endtask

  // Config is scrambled right after start to show it is sampled only at start.
  task automatic start_job(int v0, int vr, int vt, int lk, int k, int rp, int din);
    @(posedge aclk); #1;
    cfg_v_0 = VW'(v0); cfg_v_rest = VW'(vr); cfg_v_th = VW'(vt);
    cfg_v_leak = 5'(lk); cfg_k_syn = 4'(k); cfg_rp = RPW'(rp);
    in_data = IW'(din); in_valid = 1'b1; start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    cfg_v_0 = 16'sd777; cfg_v_th = '0; cfg_rp = '1; cfg_k_syn = 4'd3;
    @(negedge aclk);
    check("start_busy", busy, 1);
    check("start_in_ready_k1", in_ready, 0);
    @(negedge aclk);
    check("start_in_ready_k2", in_ready, 1);
  endtask

  task automatic wait_done(string name);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge aclk);
      if (done) seen = 1;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_done_timeout: got no done, expected done within 200 cycles", name);
    end else begin
      check({name, "_busy_at_done"}, busy, 0);
      check({name, "_outputs_left"}, q.size(), 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_counts(int exp);
    for (int a = 0; a < N; a++) begin
      @(posedge aclk); #1;
      cnt_addr = NA'(a);
      @(posedge aclk);
      @(negedge aclk);
      check("cnt_data", cnt_data, exp);
    end
  endtask

  initial begin : stim
    aresetn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_v_0 = '0; cfg_v_rest = '0; cfg_v_th = '0; cfg_v_leak = '0; cfg_k_syn = '0;
    cfg_rp = '0; cnt_addr = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_reset_values();
    @(posedge aclk); #1 aresetn = 1'b1;

    // Integrate 40/step to threshold 100: 40, 80, 120 -> spike, then 40.
    push(4'b0000, 0, 0, 0); push(4'b0000, 1, 0, 0);
    push(4'b1111, 2, 0, 0); push(4'b0000, 3, 0, 0);
    start_job(0, 0, 100, 31, 0, 0, 40);
    wait_done("integrate");
    check_counts(CNT_ON);

    // Input 120 spikes at once, rp=2 blanks two steps; first EMIT stalled 5 cycles.
    push(4'b1111, 0, 0, 0); push(4'b0000, 1, 0, 0);
    push(4'b0000, 2, 0, 0); push(4'b1111, 3, 0, 0);
    out_ready = 1'b0;
    start_job(0, 0, 100, 31, 0, 2, 120);
    begin
      bit got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(negedge aclk);
        if (out_valid) got = 1;
      end
      if (!got) begin
        n_chk++;
        n_fail++;
        $display("FAIL stall_out_valid_timeout: got no out_valid, expected within 50 cycles");
      end
      for (int c = 0; c < 5; c++) begin
        if (c > 0) @(negedge aclk);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_spikes", out_spikes, 4'b1111);
        check("stall_out_step", out_step, 0);
        check("stall_in_ready", in_ready, 0);
      end
      @(posedge aclk); #1 out_ready = 1'b1;
    end
    wait_done("refractory");
    check_counts(2 * CNT_ON);

    // Pure leak with shift 1: 64 -> 32, 16, 8, 4.
    push(4'b0000, 0, 1, 32); push(4'b0000, 1, 1, 16);
    push(4'b0000, 2, 1, 8);  push(4'b0000, 3, 1, 4);
    start_job(64, 0, 100, 1, 0, 0, 0);
    wait_done("leak");

    // -128 << 15 far below the VW range: clamps at -32768, no wrap.
    push(4'b0000, 0, 1, -32768); push(4'b0000, 1, 1, -32768);
    push(4'b0000, 2, 1, -32768); push(4'b0000, 3, 1, -32768);
    start_job(0, 0, 100, 31, 15, 0, -128);
    wait_done("saturate");

    // Abort mid-RUN after neuron 0 has integrated; no done may follow.
    start_job(0, 0, 100, 31, 0, 0, 40);
    @(posedge aclk);
    @(posedge aclk); #1 aresetn = 1'b0;
    q.delete();
    @(negedge aclk);
    check_reset_values();
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      check("abort_no_done", done, 0);
    end
    in_valid = 1'b0;
    @(posedge aclk); #1 aresetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      check("abort_idle_busy", busy, 0);
    end

    // Fresh job after the abort behaves like the first one.
    push(4'b0000, 0, 0, 0); push(4'b0000, 1, 0, 0);
    push(4'b1111, 2, 0, 0); push(4'b0000, 3, 0, 0);
    start_job(0, 0, 100, 31, 0, 0, 40);
    wait_done("after_reset");
    check_counts(CNT_ON);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
